// File: rtl/source.sv
// source: producer end of an 8-bit valid/ready stream.
// A start pulse launches a burst of NUM_WORDS bytes (0 = endless). The data is
// either an incrementing count or an 8-bit LFSR sequence. Each word is held
// until it is accepted, then GAP idle cycles follow before the next word.
module source #(
  parameter int         GAP       = 2,
  parameter int         NUM_WORDS = 8,
  parameter int         PATTERN   = 0,
  parameter logic [7:0] SEED      = 8'h01
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] count_o
);

  // An all-zero LFSR state would lock up, so a zero seed becomes 8'h01.
  localparam logic [7:0] L_SEED = (PATTERN == 1 && SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t      r_state;
  logic        r_valid;
  logic [7:0]  r_data;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_count;
  logic [15:0] r_gap_cnt;

  logic        w_xfer;
  logic        w_last;
  logic        w_gap_done;

  // Next word of the selected pattern.
  function automatic logic [7:0] f_next(input logic [7:0] d);
    if (PATTERN == 1) return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    else              return d + 8'd1;
  endfunction

  assign w_xfer     = r_valid && ready_i;
  assign w_last     = (NUM_WORDS != 0) && (int'(r_count) + 1 == NUM_WORDS);
  assign w_gap_done = (int'(r_gap_cnt) + 1 == GAP);

  // Burst FSM; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= 8'h00;
      r_gap_cnt <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_SEND;
            r_data  <= L_SEED;
            r_count <= 8'h00;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          // An accepted word always counts, even when aborting on the same edge.
          if (w_xfer) r_count <= r_count + 8'd1;
          if (abort_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (w_last) begin
              // Keep the last word on data_o; only valid drops.
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_data <= f_next(r_data);
              if (GAP != 0) begin
                r_state   <= S_GAP;
                r_valid   <= 1'b0;
                r_gap_cnt <= 16'd0;
              end
            end
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + 16'd1;
          if (abort_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_gap_done) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign count_o = r_count;

endmodule

// File: tb/tb_source.sv
// tb_source: six differently parameterised source instances, each driven on
// its own inputs. A behavioural model tracks every instance each cycle; directed
// tables/sequences cover the listed scenarios and instance 5 gets random traffic.
module tb_source;
  localparam int N = 6;
  // instance:                        u5     u4     u3     u2     u1     u0
  localparam logic [N-1:0][7:0] P_GAP  = {8'd1,  8'd0,  8'd0,  8'd0,  8'd2,  8'd0};
  localparam logic [N-1:0][7:0] P_NW   = {8'd5,  8'd0,  8'd2,  8'd6,  8'd3,  8'd4};
  localparam logic [N-1:0]      P_PAT  = 6'b100100;
  localparam logic [N-1:0][7:0] P_SEED = {8'h5A, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h10};

  logic         clk;
  logic [N-1:0] rs, st, ab, rd;
  logic         vld [N];
  logic         bsy [N];
  logic         dn  [N];
  logic [7:0]   dat [N];
  logic [7:0]   cnt [N];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    source #(
      .GAP(int'(P_GAP[g])), .NUM_WORDS(int'(P_NW[g])),
      .PATTERN(int'(P_PAT[g])), .SEED(P_SEED[g])
    ) u_dut (
      .clk_i(clk), .rst_i(rs[g]), .start_i(st[g]), .abort_i(ab[g]), .ready_i(rd[g]),
      .valid_o(vld[g]), .data_o(dat[g]), .busy_o(bsy[g]), .done_o(dn[g]), .count_o(cnt[g])
    );
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // n-th word of a burst, straight from the pattern definition.
  function automatic logic [7:0] word(input int k, input int n);
    logic [7:0] d;
    d = P_SEED[k];
    if (P_PAT[k]) begin
      if (d == 8'h00) d = 8'h01;
      for (int i = 0; i < n; i++) d = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    end else begin
      d = 8'((int'(P_SEED[k]) + n) % 256);
    end
    return d;
  endfunction

  // ---------------- reference model ----------------
  bit       m_busy [N];
  bit       m_vld  [N];
  bit       m_done [N];
  bit [7:0] m_dat  [N];
  bit [7:0] m_cnt  [N];
  int       m_idx  [N];
  int       m_gap  [N];

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      bit b, v, d, x;
      bit [7:0] dt, c;
      int ix, gl;
      b = m_busy[k]; v = m_vld[k]; dt = m_dat[k]; c = m_cnt[k];
      ix = m_idx[k]; gl = m_gap[k]; d = 0;
      if (rs[k]) begin
        b = 0; v = 0; dt = 0; c = 0; ix = 0; gl = 0;
      end else if (!b) begin
        if (st[k]) begin b = 1; v = 1; ix = 0; dt = word(k, 0); c = 0; end
      end else begin
        x = v && rd[k];
        if (x) c = c + 8'd1;
        if (ab[k]) begin
          b = 0; v = 0;
        end else if (x) begin
          if (P_NW[k] != 0 && c == P_NW[k]) begin
            b = 0; v = 0; d = 1;
          end else begin
            ix++; dt = word(k, ix); gl = int'(P_GAP[k]); v = (gl == 0);
          end
        end else if (!v) begin
          gl--;
          if (gl == 0) v = 1;
        end
      end
      m_busy[k] <= b; m_vld[k] <= v; m_done[k] <= d; m_dat[k] <= dt;
      m_cnt[k] <= c; m_idx[k] <= ix; m_gap[k] <= gl;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++)
      check($sformatf("u%0d model {vld,bsy,dn,dat,cnt}", k),
            {vld[k], bsy[k], dn[k], dat[k], cnt[k]},
            {m_vld[k], m_busy[k], m_done[k], m_dat[k], m_cnt[k]});
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    bit st; bit rd;
    bit vld; bit bsy; bit dn; logic [7:0] dat; logic [7:0] cnt;
  } vec_t;

  initial begin
    vec_t tv [7];
    logic [7:0] vp, dp, c0, d0, prev;
    logic [7:0] lfsr_exp [6];
    bit wrap;
    int ndone;

    rs = '1; st = '0; ab = '0; rd = '0;
    tick(); tick();
    for (int k = 0; k < N; k++)
      check($sformatf("u%0d reset outs", k), {vld[k], bsy[k], dn[k], dat[k], cnt[k]}, 0);
    rs = '0;

    // u0: GAP=0 NW=4 SEED=10, ready high
    tv[0] = '{1, 1, 1, 1, 0, 8'h10, 8'd0};
    tv[1] = '{0, 1, 1, 1, 0, 8'h11, 8'd1};
    tv[2] = '{0, 1, 1, 1, 0, 8'h12, 8'd2};
    tv[3] = '{0, 1, 1, 1, 0, 8'h13, 8'd3};
    tv[4] = '{0, 1, 0, 0, 1, 8'h13, 8'd4};
    tv[5] = '{0, 1, 0, 0, 0, 8'h13, 8'd4};
    tv[6] = '{0, 0, 0, 0, 0, 8'h13, 8'd4};
    for (int i = 0; i < 7; i++) begin
      st[0] = tv[i].st; rd[0] = tv[i].rd;
      tick();
      check($sformatf("u0 vec%0d", i), {vld[0], bsy[0], dn[0], dat[0], cnt[0]},
            {tv[i].vld, tv[i].bsy, tv[i].dn, tv[i].dat, tv[i].cnt});
    end
    st[0] = 0;

    // u1: GAP=2 NW=3 -> valid 1,0,0,1,0,0,1,0 and done with the last sample
    rd[1] = 1; st[1] = 1; tick(); st[1] = 0;
    for (int i = 0; i < 8; i++) begin
      vp[i] = vld[1]; dp[i] = dn[1];
      if (i < 7) tick();
    end
    check("u1 valid pattern", vp, 8'b0100_1001);
    check("u1 done pattern", dp, 8'b1000_0000);
    check("u1 final count", cnt[1], 8'd3);
    tick();

    // u1 backpressure: word held for 5 cycles, accepted on first ready
    rd[1] = 0; st[1] = 1; tick(); st[1] = 0;
    for (int i = 0; i < 5; i++) begin
      check("u1 backpressure hold", {vld[1], dat[1]}, {1'b1, 8'h01});
      tick();
    end
    rd[1] = 1; tick();
    check("u1 after release", {vld[1], cnt[1], dat[1]}, {1'b0, 8'd1, 8'h02});

    // start while busy is ignored
    st[1] = 1; tick(); st[1] = 0;
    check("u1 start while busy", {bsy[1], cnt[1]}, {1'b1, 8'd1});

    // start in the done cycle begins a new burst
    for (int i = 0; i < 40 && !dn[1]; i++) tick();
    check("u1 done seen", dn[1], 1'b1);
    st[1] = 1; tick(); st[1] = 0;
    check("u1 start on done", {vld[1], bsy[1], cnt[1], dat[1]}, {1'b1, 1'b1, 8'd0, 8'h01});
    tick();
    check("u1 in gap", {vld[1], bsy[1]}, {1'b0, 1'b1});
    rs[1] = 1; tick(); rs[1] = 0;
    check("u1 reset mid-gap", {vld[1], bsy[1], dn[1], dat[1], cnt[1]}, 0);
    tick();
    check("u1 stays idle", {vld[1], bsy[1]}, 0);

    // u2: LFSR from SEED=0
    lfsr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    rd[2] = 1; st[2] = 1; tick(); st[2] = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("u2 lfsr word%0d", i), {vld[2], dat[2]}, {1'b1, lfsr_exp[i]});
      tick();
    end
    check("u2 done", {dn[2], cnt[2]}, {1'b1, 8'd6});

    // u3: incrementing wraps FF -> 00
    rd[3] = 1; st[3] = 1; tick(); st[3] = 0;
    check("u3 word0", {vld[3], dat[3]}, {1'b1, 8'hFF});
    tick();
    check("u3 word1", {vld[3], dat[3]}, {1'b1, 8'h00});
    tick();
    check("u3 done", {dn[3], vld[3], cnt[3]}, {1'b1, 1'b0, 8'd2});

    // u4: endless burst, count wraps, no done; abort coincident with transfer
    rd[4] = 1; st[4] = 1; tick(); st[4] = 0;
    wrap = 0; ndone = 0; prev = cnt[4];
    for (int i = 0; i < 300; i++) begin
      tick();
      if (prev == 8'd255 && cnt[4] == 8'd0) wrap = 1;
      if (dn[4]) ndone++;
      prev = cnt[4];
    end
    check("u4 count wrapped", wrap, 1'b1);
    check("u4 no done", ndone, 0);
    c0 = cnt[4]; d0 = dat[4];
    ab[4] = 1; tick(); ab[4] = 0;
    check("u4 abort w/ xfer", {vld[4], bsy[4], dn[4], cnt[4], dat[4]},
          {1'b0, 1'b0, 1'b0, 8'(c0 + 8'd1), d0});
    rd[4] = 0;

    // u5: random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      st[5] = ($urandom_range(0, 7) == 0);
      ab[5] = ($urandom_range(0, 31) == 0);
      rd[5] = ($urandom_range(0, 1) == 1);
      rs[5] = ($urandom_range(0, 199) == 0);
      tick();
    end
    st = '0; ab = '0; rd = '0; rs = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/source.md
Name: source

Overview:
- Producer end of the 8-bit valid/ready stream consumed by `sink`.
- On a start pulse, emits a burst of NUM_WORDS bytes. Data is either an incrementing count or an 8-bit LFSR sequence.
- Holds each word stable until it is accepted, then inserts a programmable idle gap before the next word.
- Used as the stimulus/traffic generator on the source side of the source_sink pair.

Parameters:
- GAP, 2, number of idle cycles (valid_o low) after each accepted word before the next valid_o; 0 = back-to-back.
- NUM_WORDS, 8, words per burst; 0 = endless burst (only abort_i ends it).
- PATTERN, 0, data pattern: 0 = incrementing from SEED (+1 mod 256); 1 = LFSR.
- SEED, 8'h01, first word of each burst. In LFSR mode, SEED=0 is replaced by 8'h01.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  begin a burst; sampled only in IDLE.
- abort_i  input  1  terminate the burst; return to IDLE.
- ready_i  input  1  consumer ready.
- valid_o  output  1  data_o holds a valid word.
- data_o  output  8  payload.
- busy_o  output  1  high in SEND or GAP.
- done_o  output  1  one-cycle pulse after the last word of a finite burst is accepted.
- count_o  output  8  words accepted in the current/last burst; wraps 255->0.

Behaviour:
- All outputs are registered.
- Reset (rst_i high at an edge, overrides everything): state IDLE, valid_o=0, data_o=8'h00, busy_o=0, done_o=0, count_o=0, gap counter=0.
- Handshake: a transfer occurs at a rising edge where valid_o=1 and ready_i=1.
  - valid_o never drops without a transfer, except on abort_i or reset.
  - data_o never changes while valid_o=1 and ready_i=0.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - valid_o=0, busy_o=0.
  - start_i=1 at edge t: next state SEND; at edge t, data_o<=SEED (LFSR-corrected), count_o<=0, valid_o<=1, busy_o<=1.
  - Start-to-valid latency is 1 cycle.
- SEND: valid_o=1; waits indefinitely for ready_i. On a transfer at edge t:
  - count_o<=count_o+1 (mod 256).
  - If NUM_WORDS!=0 and count_o+1==NUM_WORDS:
    - next state IDLE; valid_o<=0, busy_o<=0, done_o<=1 for exactly one cycle.
    - data_o keeps the last word.
  - Otherwise data_o<=next word at edge t:
    - GAP=0: stay in SEND with valid_o=1 (back-to-back, one word per cycle when ready_i stays high).
    - GAP>0: next state GAP, valid_o<=0, gap counter<=0.
- GAP:
  - valid_o=0, busy_o=1.
  - The counter increments each cycle. When counter+1==GAP, next state SEND and valid_o<=1.
  - valid_o is therefore low for exactly GAP cycles after each transfer.
- Next word:
  - PATTERN=0: data+1, wrapping 8'hFF->8'h00.
  - PATTERN=1: {d[6:0], d[7]^d[5]^d[4]^d[3]}. From 8'h01: 01,02,04,08,11,23,...
- start_i while busy_o=1 is ignored.
- start_i in the same cycle done_o=1 is accepted, because the state is IDLE.
- abort_i=1 at edge t in SEND or GAP:
  - next state IDLE; valid_o<=0, busy_o<=0; done_o stays 0.
  - If a transfer also occurs at edge t, it counts (count_o increments) and data_o is not advanced.
  - abort_i in IDLE has no effect. abort_i has priority over start_i in the same cycle only when busy.
- done_o is never asserted when NUM_WORDS=0.
- count_o holds its final value in IDLE until the next accepted start_i.
- Reset mid-burst: immediate return to reset values at that edge. No done_o, no further valid_o.

Test Plan:
- GAP=0, NUM_WORDS=4, PATTERN=0, SEED=8'h10, ready_i tied high, start_i pulse at cycle 0 -> valid_o high cycles 1-4 with data 10,11,12,13; done_o=1 in cycle 5 only; count_o=4; busy_o low from cycle 5.
- GAP=2, NUM_WORDS=3, ready_i high -> valid_o pattern 1,0,0,1,0,0,1 then 0; done_o pulse 1 cycle after the third transfer; count_o=3.
- Backpressure: ready_i low for 5 cycles while valid_o=1 -> valid_o stays 1 and data_o is unchanged every cycle; transfer on the first ready_i=1 edge.
- PATTERN=1, SEED=8'h00, GAP=0, NUM_WORDS=6 -> words 01,02,04,08,11,23; SEED=8'hFF, PATTERN=0, NUM_WORDS=2 -> FF,00.
- NUM_WORDS=0, GAP=0, ready_i high for 300 cycles -> continuous transfers, count_o wraps 255->0, no done_o. Then abort_i coincident with a transfer -> count_o increments once, valid_o low next cycle, done_o stays 0.
- start_i asserted while busy (ignored, count_o not cleared); start_i in the done_o cycle (new burst starts, count_o<=0). rst_i mid-GAP -> all outputs take reset values at that edge.
